// File: rtl/ir_drive_ctrl_if.sv
// Command bus between the IR receiver / autonomous controller and the drive controller.
interface ir_drive_ctrl_if;
    logic       i_ir_data_en;
    logic       i_ir_repeat_en;
    logic [7:0] i_ir_data;
    logic       i_auto_req;
    logic [2:0] i_auto_cmd;
    logic [2:0] o_motor_cmd;
    logic [1:0] o_speed_lvl;
    logic       o_auto_mode;
    logic       o_cmd_valid;

    // Source side: receiver, autonomous controller and motor driver as seen from outside
    modport master (
        output i_ir_data_en,
        output i_ir_repeat_en,
        output i_ir_data,
        output i_auto_req,
        output i_auto_cmd,
        input  o_motor_cmd,
        input  o_speed_lvl,
        input  o_auto_mode,
        input  o_cmd_valid
    );

    // Controller side
    modport slave (
        input  i_ir_data_en,
        input  i_ir_repeat_en,
        input  i_ir_data,
        input  i_auto_req,
        input  i_auto_cmd,
        output o_motor_cmd,
        output o_speed_lvl,
        output o_auto_mode,
        output o_cmd_valid
    );
endinterface

// File: rtl/ir_drive_ctrl.sv
// IR key events -> registered motor commands, with hold timeout, auto-mode
// arbitration and a saturating speed level.
module ir_drive_ctrl #(
    parameter int unsigned HOLD_CYC = 7_500_000
) (
    input  logic           sys_clk,
    input  logic           sys_rst_n,
    ir_drive_ctrl_if.slave bus
);
    localparam logic [7:0]  KEY_FWD    = 8'h18;
    localparam logic [7:0]  KEY_BACK   = 8'h52;
    localparam logic [7:0]  KEY_LEFT   = 8'h08;
    localparam logic [7:0]  KEY_RIGHT  = 8'h5A;
    localparam logic [7:0]  KEY_STOP   = 8'h1C;
    localparam logic [7:0]  KEY_MODE   = 8'h45;
    localparam logic [7:0]  KEY_SPD_UP = 8'h15;
    localparam logic [7:0]  KEY_SPD_DN = 8'h07;
    localparam logic [22:0] HOLD_LAST  = 23'(HOLD_CYC - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_MOVE, ST_AUTO} state_e;

    logic [2:0]  r_den_sync;
    logic [2:0]  r_rep_sync;
    logic        w_data_evt;
    logic        w_rep_evt;
    logic [7:0]  r_key;
    logic        r_key_vld;
    logic        r_rep_vld;
    state_e      r_state;
    state_e      w_state_d;
    logic [2:0]  r_cmd;
    logic [2:0]  w_cmd_d;
    logic [1:0]  r_spd;
    logic [1:0]  w_spd_d;
    logic [22:0] r_timer;
    logic [22:0] w_timer_d;
    logic        r_cmd_valid;
    logic        w_cmd_valid_d;
    logic        w_is_dir;
    logic [2:0]  w_dir_cmd;
    logic [2:0]  w_auto_cmd;
    logic        w_key_dir;
    logic        w_key_stop;
    logic        w_key_mode;
    logic        w_key_up;
    logic        w_key_dn;

    // Bring the slow-domain pulses into sys_clk; bit 0 is the first flop
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_den_sync <= 3'b000;
            r_rep_sync <= 3'b000;
        end else begin
            r_den_sync <= {r_den_sync[1:0], bus.i_ir_data_en};
            r_rep_sync <= {r_rep_sync[1:0], bus.i_ir_repeat_en};
        end
    end

    assign w_data_evt = r_den_sync[1] & ~r_den_sync[2];
    assign w_rep_evt  = r_rep_sync[1] & ~r_rep_sync[2];

    // Latch the key on its event; a coincident repeat is dropped in favour of the key
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_key     <= 8'h00;
            r_key_vld <= 1'b0;
            r_rep_vld <= 1'b0;
        end else begin
            r_key_vld <= w_data_evt;
            r_rep_vld <= w_rep_evt & ~w_data_evt;
            if (w_data_evt) begin
                r_key <= bus.i_ir_data;
            end
        end
    end

    // Map direction keys onto motor command codes
    always_comb begin
        w_is_dir  = 1'b1;
        w_dir_cmd = 3'd0;
        case (r_key)
            KEY_FWD:   w_dir_cmd = 3'd1;
            KEY_BACK:  w_dir_cmd = 3'd2;
            KEY_LEFT:  w_dir_cmd = 3'd3;
            KEY_RIGHT: w_dir_cmd = 3'd4;
            default:   w_is_dir  = 1'b0;
        endcase
    end

    assign w_key_dir  = r_key_vld & w_is_dir;
    assign w_key_stop = r_key_vld & (r_key == KEY_STOP);
    assign w_key_mode = r_key_vld & (r_key == KEY_MODE);
    assign w_key_up   = r_key_vld & (r_key == KEY_SPD_UP);
    assign w_key_dn   = r_key_vld & (r_key == KEY_SPD_DN);

    // Codes 5..7 from the autonomous side are not valid motions
    assign w_auto_cmd = (bus.i_auto_req && (bus.i_auto_cmd <= 3'd4)) ? bus.i_auto_cmd : 3'd0;

    // Next state, command, hold timer, speed level and change strobe
    always_comb begin
        w_state_d = r_state;
        w_cmd_d   = r_cmd;
        w_spd_d   = r_spd;
        w_timer_d = 23'd0;
        case (r_state)
            ST_IDLE: begin
                if (w_key_dir) begin
                    w_state_d = ST_MOVE;
                    w_cmd_d   = w_dir_cmd;
                end else if (w_key_mode) begin
                    w_state_d = ST_AUTO;
                    w_cmd_d   = w_auto_cmd;
                end
            end
            ST_MOVE: begin
                // A key outranks a timeout landing in the same cycle
                if (w_key_dir) begin
                    w_cmd_d = w_dir_cmd;
                end else if (w_key_stop) begin
                    w_state_d = ST_IDLE;
                    w_cmd_d   = 3'd0;
                end else if (w_key_mode) begin
                    w_state_d = ST_AUTO;
                    w_cmd_d   = w_auto_cmd;
                end else if (r_rep_vld) begin
                    w_timer_d = 23'd0;
                end else if (r_timer == HOLD_LAST) begin
                    w_state_d = ST_IDLE;
                    w_cmd_d   = 3'd0;
                end else begin
                    w_timer_d = r_timer + 23'd1;
                end
            end
            ST_AUTO: begin
                if (w_key_stop || w_key_mode) begin
                    w_state_d = ST_IDLE;
                    w_cmd_d   = 3'd0;
                end else begin
                    w_cmd_d = w_auto_cmd;
                end
            end
            default: begin
                w_state_d = ST_IDLE;
                w_cmd_d   = 3'd0;
            end
        endcase
        if (w_key_up && (r_spd != 2'd3)) begin
            w_spd_d = r_spd + 2'd1;
        end else if (w_key_dn && (r_spd != 2'd0)) begin
            w_spd_d = r_spd - 2'd1;
        end
        w_cmd_valid_d = (w_cmd_d != r_cmd) || (w_spd_d != r_spd) ||
                        ((w_state_d == ST_AUTO) != (r_state == ST_AUTO));
    end

    // Registered outputs and FSM state
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state     <= ST_IDLE;
            r_cmd       <= 3'd0;
            r_spd       <= 2'd0;
            r_timer     <= 23'd0;
            r_cmd_valid <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_cmd       <= w_cmd_d;
            r_spd       <= w_spd_d;
            r_timer     <= w_timer_d;
            r_cmd_valid <= w_cmd_valid_d;
        end
    end

    assign bus.o_motor_cmd = r_cmd;
    assign bus.o_speed_lvl = r_spd;
    assign bus.o_auto_mode = (r_state == ST_AUTO);
    assign bus.o_cmd_valid = r_cmd_valid;
endmodule

// File: tb/tb_ir_drive_ctrl.sv
// Directed and randomized key sequences checked against a key-event level model.
module tb_ir_drive_ctrl;
    localparam int unsigned HOLD = 100;
    localparam logic [7:0] K_FWD   = 8'h18;
    localparam logic [7:0] K_BACK  = 8'h52;
    localparam logic [7:0] K_LEFT  = 8'h08;
    localparam logic [7:0] K_RIGHT = 8'h5A;
    localparam logic [7:0] K_STOP  = 8'h1C;
    localparam logic [7:0] K_MODE  = 8'h45;
    localparam logic [7:0] K_UP    = 8'h15;
    localparam logic [7:0] K_DN    = 8'h07;

    logic        sys_clk   = 1'b0;
    logic        sys_rst_n = 1'b0;
    int unsigned cyc       = 0;
    int          errors    = 0;
    int          checks    = 0;

    // Model: current mode, command, speed and the edge count of the last timer clear
    logic        m_auto;
    logic        m_move;
    logic [2:0]  m_cmd;
    logic [1:0]  m_spd;
    int unsigned m_tclr;

    ir_drive_ctrl_if bus();

    ir_drive_ctrl #(.HOLD_CYC(HOLD)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .bus       (bus)
    );

    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic exp_valid);
        check({tag, ".cmd"}, 32'(bus.o_motor_cmd), 32'(m_cmd));
        check({tag, ".spd"}, 32'(bus.o_speed_lvl), 32'(m_spd));
        check({tag, ".auto"}, 32'(bus.o_auto_mode), 32'(m_auto));
        check({tag, ".valid"}, 32'(bus.o_cmd_valid), 32'(exp_valid));
    endtask

    function automatic logic [2:0] auto_val();
        if (!bus.i_auto_req || bus.i_auto_cmd > 3'd4) return 3'd0;
        return bus.i_auto_cmd;
    endfunction

    function automatic logic [2:0] dir_of(input logic [7:0] k);
        if (k == K_FWD)  return 3'd1;
        if (k == K_BACK) return 3'd2;
        if (k == K_LEFT) return 3'd3;
        return 3'd4;
    endfunction

    task automatic model_reset();
        m_auto = 1'b0;
        m_move = 1'b0;
        m_cmd  = 3'd0;
        m_spd  = 2'd0;
        m_tclr = 0;
    endtask

    // Apply one key to the model; returns whether any output changed
    task automatic model_key(input logic [7:0] k, output logic changed);
        logic [2:0] oc;
        logic [1:0] os;
        logic       oa;
        oc = m_cmd;
        os = m_spd;
        oa = m_auto;
        case (k)
            K_FWD, K_BACK, K_LEFT, K_RIGHT: begin
                if (!m_auto) begin
                    m_move = 1'b1;
                    m_cmd  = dir_of(k);
                    m_tclr = cyc;
                end
            end
            K_STOP: begin
                m_auto = 1'b0;
                m_move = 1'b0;
                m_cmd  = 3'd0;
            end
            K_MODE: begin
                if (m_auto) begin
                    m_auto = 1'b0;
                    m_cmd  = 3'd0;
                end else begin
                    m_auto = 1'b1;
                    m_move = 1'b0;
                    m_cmd  = auto_val();
                end
            end
            K_UP:    if (m_spd != 2'd3) m_spd = m_spd + 2'd1;
            K_DN:    if (m_spd != 2'd0) m_spd = m_spd - 2'd1;
            default: ;
        endcase
        changed = (oc != m_cmd) || (os != m_spd) || (oa != m_auto);
    endtask

    // One receiver data pulse (optionally with a coincident repeat pulse)
    task automatic send(input logic [7:0] k, input logic with_rep);
        logic ch;
        @(negedge sys_clk);
        bus.i_ir_data      = k;
        bus.i_ir_data_en   = 1'b1;
        bus.i_ir_repeat_en = with_rep;
        repeat (4) @(negedge sys_clk);
        model_key(k, ch);
        check_outs($sformatf("key%02h", k), ch);
        @(negedge sys_clk);
        check("valid_one_cycle", 32'(bus.o_cmd_valid), 32'd0);
        repeat ($urandom_range(0, 3)) @(negedge sys_clk);
        bus.i_ir_data_en   = 1'b0;
        bus.i_ir_repeat_en = 1'b0;
        bus.i_ir_data      = 8'($urandom);
        repeat (4) @(negedge sys_clk);
    endtask

    task automatic send_rep();
        @(negedge sys_clk);
        bus.i_ir_repeat_en = 1'b1;
        repeat (4) @(negedge sys_clk);
        if (m_move) m_tclr = cyc;
        check_outs("repeat", 1'b0);
        repeat (2) @(negedge sys_clk);
        bus.i_ir_repeat_en = 1'b0;
        repeat (4) @(negedge sys_clk);
    endtask

    task automatic set_auto(input logic req, input logic [2:0] c);
        logic [2:0] oc;
        @(negedge sys_clk);
        bus.i_auto_req = req;
        bus.i_auto_cmd = c;
        @(negedge sys_clk);
        oc = m_cmd;
        if (m_auto) m_cmd = auto_val();
        check_outs("auto_in", oc != m_cmd);
    endtask

    // Motion must last exactly HOLD edges past the last clearing edge
    task automatic wait_timeout();
        while (cyc < m_tclr + HOLD - 1) @(negedge sys_clk);
        check("hold_last", 32'(bus.o_motor_cmd), 32'(m_cmd));
        @(negedge sys_clk);
        m_move = 1'b0;
        m_cmd  = 3'd0;
        check_outs("timeout", 1'b1);
        @(negedge sys_clk);
        check("timeout_valid_low", 32'(bus.o_cmd_valid), 32'd0);
    endtask

    initial begin
        logic [7:0] keys [8];
        logic [7:0] k;
        keys[0] = K_FWD;  keys[1] = K_BACK; keys[2] = K_LEFT; keys[3] = K_RIGHT;
        keys[4] = K_STOP; keys[5] = K_MODE; keys[6] = K_UP;   keys[7] = K_DN;
        bus.i_ir_data_en   = 1'b0;
        bus.i_ir_repeat_en = 1'b0;
        bus.i_ir_data      = 8'h00;
        bus.i_auto_req     = 1'b0;
        bus.i_auto_cmd     = 3'd0;
        model_reset();

        // Reset values, and no strobe on release
        repeat (3) @(negedge sys_clk);
        check_outs("reset", 1'b0);
        sys_rst_n = 1'b1;
        repeat (3) @(negedge sys_clk);
        check_outs("post_reset", 1'b0);

        // Forward then timeout without repeats
        send(K_FWD, 1'b0);
        wait_timeout();

        // Repeats every 60 cycles keep the car moving
        send(K_FWD, 1'b0);
        for (int i = 0; i < 5; i++) begin
            while (cyc < m_tclr + 56) begin
                @(negedge sys_clk);
                check("held", 32'(bus.o_motor_cmd), 32'd1);
            end
            send_rep();
        end
        wait_timeout();

        // Auto mode passthrough and override keys
        set_auto(1'b1, 3'd3);
        send(K_MODE, 1'b0);
        send(K_LEFT, 1'b0);
        set_auto(1'b1, 3'd6);
        set_auto(1'b1, 3'd2);
        set_auto(1'b0, 3'd2);
        send(K_STOP, 1'b0);

        // Speed saturation both ways
        for (int i = 0; i < 5; i++) send(K_UP, 1'b0);
        check("spd_top", 32'(bus.o_speed_lvl), 32'd3);
        for (int i = 0; i < 4; i++) send(K_DN, 1'b0);
        check("spd_bottom", 32'(bus.o_speed_lvl), 32'd0);

        // Key and repeat together: key wins and clears the timer; unknown key is inert
        send(K_FWD, 1'b0);
        send(K_BACK, 1'b1);
        send(8'hAA, 1'b0);
        wait_timeout();

        // Asynchronous reset during motion
        send(K_RIGHT, 1'b0);
        send(K_UP, 1'b0);
        #2;
        sys_rst_n = 1'b0;
        #1;
        model_reset();
        check_outs("async_reset", 1'b0);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge sys_clk);
            check_outs("reset_release", 1'b0);
        end

        // Randomized key sequences
        for (int i = 0; i < 60; i++) begin
            if (m_move && (cyc - m_tclr > 60 || $urandom_range(0, 7) == 0)) wait_timeout();
            if ($urandom_range(0, 3) == 0) set_auto(1'($urandom), 3'($urandom_range(0, 7)));
            if (m_move && cyc - m_tclr > 60) wait_timeout();
            if ($urandom_range(0, 9) == 0) begin
                k = 8'($urandom);
            end else begin
                k = keys[$urandom_range(0, 7)];
            end
            if ($urandom_range(0, 5) == 0) begin
                send_rep();
            end else begin
                send(k, ($urandom_range(0, 4) == 0));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
